// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter feeding the register-file select decoder, strobe and data.
// Optional macro REGARB_R0_PROTECT_EN: register 0 is read-only; writes to it are granted but flagged on err.
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    addr,
  input  logic [DW*NREQ-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           sel,
  output logic                 we,
  output logic [DW-1:0]        wdata,
  output logic                 busy,
  output logic                 err
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   last;
  logic [LW-1:0]   cand;
  logic            win_valid;
  logic [LW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [3:0]      win_addr;
  logic [DW-1:0]   win_data;
  logic            launch;
  logic            wr_blocked;

  // Scan from the farthest candidate back to last+1 so the nearest requester overwrites any earlier hit.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    win_valid = 1'b0;
    win_idx   = last;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = LW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr   = '0;
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (LW'(i) == win_idx) begin
        win_addr      = addr[4*i +: 4];
        win_data      = data[DW*i +: DW];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_valid) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WRITE);
  end

  assign launch = (state == IDLE) && win_valid;

`ifdef REGARB_R0_PROTECT_EN
  assign wr_blocked = (win_addr == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= launch && wr_blocked;
    end
  end
`else
  assign wr_blocked = 1'b0;
  assign err        = 1'b0;
`endif

  // Strobe and grant default low so each lasts exactly the single WRITE cycle; sel/wdata hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= '0;
      sel   <= '0;
      we    <= 1'b0;
      wdata <= '0;
      last  <= LW'(NREQ - 1);
    end else begin
      gnt <= '0;
      we  <= 1'b0;
      if (launch) begin
        gnt   <= win_onehot;
        sel   <= win_addr;
        wdata <= win_data;
        we    <= !wr_blocked;
        last  <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vectors, multi-cycle corner sequences and
// randomized traffic against a rotating-priority reference model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [4*NREQ-1:0]  addr;
  logic [DW*NREQ-1:0] data;
  logic [NREQ-1:0] gnt;
  logic [3:0]      sel;
  logic            we;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .addr  (addr),
    .data  (data),
    .gnt   (gnt),
    .sel   (sel),
    .we    (we),
    .wdata (wdata),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time (got timeout, required completion)");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  v_req;
    logic [15:0] v_addr;
    logic [63:0] v_data;
    logic [3:0]  e_gnt;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [15:0] e_wdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: pointer of the last winner plus the expected registered outputs.
  int          m_last;
  bit          m_busy;
  logic [3:0]  m_gnt;
  logic        m_we;
  logic        m_err;
  logic [3:0]  m_sel;
  logic [15:0] m_wdata;
  int          waits[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner = first requester in the rotating order last+1, last+2, ... (mod NREQ).
  task automatic model_edge();
    int order[$];
    int w;
    w = -1;
    if (m_busy) begin
      m_busy = 1'b0;
      m_gnt  = '0;
      m_we   = 1'b0;
      m_err  = 1'b0;
    end else if (req != '0) begin
      for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
      foreach (order[j]) if (w < 0 && req[order[j]]) w = order[j];
      m_last  = w;
      m_busy  = 1'b1;
      m_gnt   = 4'(1 << w);
      m_sel   = addr[4*w +: 4];
      m_wdata = data[DW*w +: DW];
      m_we    = 1'b1;
      m_err   = 1'b0;
`ifdef REGARB_R0_PROTECT_EN
      if (m_sel == 4'd0) begin
        m_we  = 1'b0;
        m_err = 1'b1;
      end
`endif
    end else begin
      m_gnt = '0;
      m_we  = 1'b0;
      m_err = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{4'b0100, 16'h0A00, 64'h0000_1234_0000_0000, 4'b0100, 1'b1, 4'hA, 16'h1234, 1'b1};
    vecs[1] = '{4'b0000, 16'h0A00, 64'h0000_1234_0000_0000, 4'b0000, 1'b0, 4'hA, 16'h1234, 1'b0};
    vecs[2] = '{4'b0111, 16'h0321, 64'h0000_3333_2222_1111, 4'b0001, 1'b1, 4'h1, 16'h1111, 1'b1};
    vecs[3] = '{4'b0110, 16'h0321, 64'h0000_3333_2222_1111, 4'b0000, 1'b0, 4'h1, 16'h1111, 1'b0};
    vecs[4] = '{4'b0110, 16'h0321, 64'h0000_3333_2222_1111, 4'b0010, 1'b1, 4'h2, 16'h2222, 1'b1};
    vecs[5] = '{4'b0100, 16'h0321, 64'h0000_3333_2222_1111, 4'b0000, 1'b0, 4'h2, 16'h2222, 1'b0};
    vecs[6] = '{4'b0100, 16'h0321, 64'h0000_3333_2222_1111, 4'b0100, 1'b1, 4'h3, 16'h3333, 1'b1};
    vecs[7] = '{4'b0000, 16'h0321, 64'h0000_3333_2222_1111, 4'b0000, 1'b0, 4'h3, 16'h3333, 1'b0};

    // Reset with every requester asking: outputs must stay cleared.
    rst_n = 1'b0;
    req   = 4'b1111;
    addr  = 16'h4321;
    data  = 64'h4444_3333_2222_1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_we", 64'(we), 64'h0);
    check("rst_sel", 64'(sel), 64'h0);
    check("rst_wdata", 64'(wdata), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    rst_n = 1'b1;

    // Fairness: two rounds of all-request, each granted in order 0..3 every other cycle.
    for (int round = 0; round < 2; round++) begin
      req = 4'b1111;
      for (int g = 0; g < NREQ; g++) begin
        step();
        check($sformatf("fair_gnt_r%0d_%0d", round, g), 64'(gnt), 64'(1 << g));
        check($sformatf("fair_we_r%0d_%0d", round, g), 64'(we), 64'h1);
        check($sformatf("fair_sel_r%0d_%0d", round, g), 64'(sel), 64'(g + 1));
        check($sformatf("fair_wdata_r%0d_%0d", round, g), 64'(wdata), 64'(16'(g + 1) * 16'h1111));
        check($sformatf("fair_busy_r%0d_%0d", round, g), 64'(busy), 64'h1);
        req[g] = 1'b0;
        step();
        check($sformatf("fair_gap_r%0d_%0d", round, g), 64'({gnt, we, busy}), 64'h0);
      end
    end

    // Directed vectors: single write, then rotation starting after requester 2.
    for (int i = 0; i < 8; i++) begin
      req  = vecs[i].v_req;
      addr = vecs[i].v_addr;
      data = vecs[i].v_data;
      step();
      check($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vecs[i].e_gnt));
      check($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].e_we));
      check($sformatf("vec%0d_sel", i), 64'(sel), 64'(vecs[i].e_sel));
      check($sformatf("vec%0d_wdata", i), 64'(wdata), 64'(vecs[i].e_wdata));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d_err", i), 64'(err), 64'h0);
    end

    // Reset in the middle of requester 1's write: strobe and grant drop without a clock edge.
    req  = 4'b0010;
    addr = 16'h0050;
    data = 64'h0000_0000_5555_0000;
    step();
    check("midrst_pre_gnt", 64'(gnt), 64'h2);
    check("midrst_pre_we", 64'(we), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_gnt", 64'(gnt), 64'h0);
    check("midrst_async_we", 64'(we), 64'h0);
    check("midrst_async_busy", 64'(busy), 64'h0);
    req  = 4'b0011;
    addr = 16'h0056;
    data = 64'h0000_0000_5555_6666;
    step();
    rst_n = 1'b1;
    step();
    check("midrst_first_gnt", 64'(gnt), 64'h1);
    check("midrst_first_sel", 64'(sel), 64'h6);
    check("midrst_first_wdata", 64'(wdata), 64'h6666);
    req = 4'b0000;
    step();

    // Write aimed at register 0.
    req  = 4'b0001;
    addr = 16'h0000;
    data = 64'h0000_0000_0000_BEEF;
    step();
    check("r0_gnt", 64'(gnt), 64'h1);
    check("r0_sel", 64'(sel), 64'h0);
    check("r0_wdata", 64'(wdata), 64'hBEEF);
    check("r0_busy", 64'(busy), 64'h1);
`ifdef REGARB_R0_PROTECT_EN
    check("r0_we", 64'(we), 64'h0);
    check("r0_err", 64'(err), 64'h1);
`else
    check("r0_we", 64'(we), 64'h1);
    check("r0_err", 64'(err), 64'h0);
`endif
    req = 4'b0000;
    step();
    check("r0_after_err", 64'(err), 64'h0);

    // Randomized traffic against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    m_last  = NREQ - 1;
    m_busy  = 1'b0;
    m_gnt   = '0;
    m_we    = 1'b0;
    m_err   = 1'b0;
    m_sel   = '0;
    m_wdata = '0;
    foreach (waits[i]) waits[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]          = 1'b1;
          addr[4*i +: 4]  = 4'($urandom_range(0, 15));
          data[DW*i +: DW] = 16'($urandom);
          waits[i]        = 0;
        end
      end
      model_edge();
      step();
      check("rnd_gnt", 64'(gnt), 64'(m_gnt));
      check("rnd_we", 64'(we), 64'(m_we));
      check("rnd_sel", 64'(sel), 64'(m_sel));
      check("rnd_wdata", 64'(wdata), 64'(m_wdata));
      check("rnd_busy", 64'(busy), 64'(m_busy));
      check("rnd_err", 64'(err), 64'(m_err));
      if (m_gnt != '0) begin
        check($sformatf("rnd_wait_bound_req%0d", m_last), 64'(waits[m_last] <= NREQ - 1), 64'h1);
        for (int i = 0; i < NREQ; i++)
          if (i != m_last && req[i]) waits[i]++;
        req[m_last] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
